photon_gate_sequencer: RTL and testbench

Acquisition sequencer for the two-detector time-correlation path. On a start command it clears its counters, opens a counting gate for a programmed number of clock cycles, and counts shaped single-cycle pulses from two pulse shapers (signal A, reference B) plus A/B coincidences. It then holds the result under a valid/ready handshake for the readout logic. The block sits between the two pulse shapers and the host/readout interface, and its `gate` output enables the shapers.

---
 rtl/photon_gate_sequencer_if.sv | 30 +++
 rtl/photon_gate_sequencer.sv | 145 ++++++++++++++
 tb/tb_photon_gate_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/photon_gate_sequencer_if.sv
// Handshake/bus bundle for photon_gate_sequencer.
// Host controls, shaper pulses, gate and the held result with valid/ready.
interface photon_gate_sequencer_if #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 24
);
   logic             start;
   logic             abort;
   logic [WIN_W-1:0] win_len;
   logic             pulse_a;
   logic             pulse_b;
   logic             gate;
   logic             busy;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic [CNT_W-1:0] cnt_ab;
   logic             sat;
   logic             res_valid;
   logic             res_ready;

   modport master (
      output start, abort, win_len, pulse_a, pulse_b, res_ready,
      input  gate, busy, cnt_a, cnt_b, cnt_ab, sat, res_valid
   );

   modport slave (
      input  start, abort, win_len, pulse_a, pulse_b, res_ready,
      output gate, busy, cnt_a, cnt_b, cnt_ab, sat, res_valid
   );
endinterface

// File: rtl/photon_gate_sequencer.sv
// Gated two-channel pulse counter with A/B coincidence detection.
// Ports: clk, rst (async, active high), bus (slave: start/abort/win_len,
// pulse_a/b in; gate, busy, cnt_a/b/ab, sat, res_valid/res_ready out).
module photon_gate_sequencer #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 24,
   parameter int COINC = 3
) (
   input logic                   clk,
   input logic                   rst,
   photon_gate_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARM, COUNT, HOLD} state_t;

   localparam logic [2:0] CMAX = 3'(COINC);

   state_t           state, state_nxt;
   logic [WIN_W-1:0] rem, rem_nxt;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_ab;
   logic [CNT_W-1:0] a_nxt, b_nxt, ab_nxt;
   logic             sat, sat_nxt;
   logic [2:0]       age_a, age_b;
   logic             rec_a, rec_b;
   logic [3:0]       trk_a, trk_b;
   logic             clr, pa, pb, coinc;

   function automatic logic [CNT_W-1:0] inc(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      return (en && v != '1) ? v + CNT_W'(1) : v;
   endfunction

   // Returns {recent, age}. rec stays set while the partner pulse would
   // still be within COINC cycles of this one; age saturates at COINC.
   function automatic logic [3:0] track(
      input logic [2:0] age,
      input logic       rec,
      input logic       hit,
      input logic       used
   );
      logic [3:0] nx;
      nx = {1'b0, age} + 4'd1;
      if (used)
         return 4'b0000;
      else if (hit)
         return {COINC != 0, 3'd0};
      else
         return {rec & (nx < 4'(COINC)),
                 (age == CMAX) ? age : nx[2:0]};
   endfunction

   assign pa    = bus.pulse_a & (state == COUNT);
   assign pb    = bus.pulse_b & (state == COUNT);
   assign coinc = (pa & pb) | (pa & rec_b) | (pb & rec_a);
   assign trk_a = track(age_a, rec_a, pa, coinc);
   assign trk_b = track(age_b, rec_b, pb, coinc);

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      clr       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = ARM;
               rem_nxt   = bus.win_len;
            end
         end
         ARM: begin
            clr = 1'b1;
            if (bus.abort)
               state_nxt = IDLE;
            else if (rem == '0)
               state_nxt = HOLD;
            else
               state_nxt = COUNT;
         end
         COUNT: begin
            rem_nxt = rem - WIN_W'(1);
            if (bus.abort)
               state_nxt = IDLE;
            else if (rem == WIN_W'(1))
               state_nxt = HOLD;
         end
         HOLD: begin
            if (bus.res_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      a_nxt   = inc(cnt_a, pa);
      b_nxt   = inc(cnt_b, pb);
      ab_nxt  = inc(cnt_ab, coinc);
      sat_nxt = sat | (&a_nxt) | (&b_nxt) | (&ab_nxt);
      if (clr) begin
         a_nxt   = '0;
         b_nxt   = '0;
         ab_nxt  = '0;
         sat_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rem    <= '0;
         cnt_a  <= '0;
         cnt_b  <= '0;
         cnt_ab <= '0;
         sat    <= 1'b0;
         age_a  <= '0;
         age_b  <= '0;
         rec_a  <= 1'b0;
         rec_b  <= 1'b0;
      end else begin
         state  <= state_nxt;
         rem    <= rem_nxt;
         cnt_a  <= a_nxt;
         cnt_b  <= b_nxt;
         cnt_ab <= ab_nxt;
         sat    <= sat_nxt;
         if (clr) begin
            age_a <= '0;
            age_b <= '0;
            rec_a <= 1'b0;
            rec_b <= 1'b0;
         end else begin
            {rec_a, age_a} <= trk_a;
            {rec_b, age_b} <= trk_b;
         end
      end
   end

   assign bus.gate      = (state == COUNT);
   assign bus.busy      = (state != IDLE);
   assign bus.res_valid = (state == HOLD);
   assign bus.cnt_a     = cnt_a;
   assign bus.cnt_b     = cnt_b;
   assign bus.cnt_ab    = cnt_ab;
   assign bus.sat       = sat;
endmodule

// File: tb/tb_photon_gate_sequencer.sv
// Bench for photon_gate_sequencer: a 16-bit and a 4-bit counter instance
// share stimulus and are compared against an event-level reference model.
module tb_photon_gate_sequencer;
   localparam int WIN_W = 24;
   localparam int COINC = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   photon_gate_sequencer_if #(.CNT_W(16), .WIN_W(WIN_W)) b16 ();
   photon_gate_sequencer_if #(.CNT_W(4),  .WIN_W(WIN_W)) b4 ();

   photon_gate_sequencer #(.CNT_W(16), .WIN_W(WIN_W), .COINC(COINC)) dut16 (
      .clk(clk), .rst(rst), .bus(b16.slave));
   photon_gate_sequencer #(.CNT_W(4), .WIN_W(WIN_W), .COINC(COINC)) dut4 (
      .clk(clk), .rst(rst), .bus(b4.slave));

   logic             start, abort, pa, pb, rdy;
   logic [WIN_W-1:0] win;

   assign b16.start     = start;
   assign b16.abort     = abort;
   assign b16.win_len   = win;
   assign b16.pulse_a   = pa;
   assign b16.pulse_b   = pb;
   assign b16.res_ready = rdy;
   assign b4.start      = start;
   assign b4.abort      = abort;
   assign b4.win_len    = win;
   assign b4.pulse_a    = pa;
   assign b4.pulse_b    = pb;
   assign b4.res_ready  = rdy;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: raw event counts and the time of the last
   // unconsumed pulse on each channel.
   int na, nb, nab, la, lb;
   logic [255:0] va, vb;

   task automatic m_clear();
      na = 0; nb = 0; nab = 0; la = -1000; lb = -1000;
   endtask

   task automatic m_pulse(input int k, input bit a, input bit b);
      bit c;
      c = (a && b) || (a && (k - lb) <= COINC) || (b && (k - la) <= COINC);
      if (a) na++;
      if (b) nb++;
      if (c) begin
         nab++; la = -1000; lb = -1000;
      end else begin
         if (a) la = k;
         if (b) lb = k;
      end
   endtask

   function automatic logic [31:0] cap(input int n, input int m);
      return 32'((n > m) ? m : n);
   endfunction

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", t, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string t, input bit g, input bit bs, input bit v);
      chk({t, ".gate16"}, 32'(b16.gate), 32'(g));
      chk({t, ".busy16"}, 32'(b16.busy), 32'(bs));
      chk({t, ".valid16"}, 32'(b16.res_valid), 32'(v));
      chk({t, ".gate4"}, 32'(b4.gate), 32'(g));
      chk({t, ".busy4"}, 32'(b4.busy), 32'(bs));
      chk({t, ".valid4"}, 32'(b4.res_valid), 32'(v));
   endtask

   task automatic chk_out(input string t);
      int mx;
      mx = na;
      if (nb > mx) mx = nb;
      if (nab > mx) mx = nab;
      chk({t, ".a16"}, 32'(b16.cnt_a), cap(na, 65535));
      chk({t, ".b16"}, 32'(b16.cnt_b), cap(nb, 65535));
      chk({t, ".ab16"}, 32'(b16.cnt_ab), cap(nab, 65535));
      chk({t, ".sat16"}, 32'(b16.sat), 32'(mx >= 65535));
      chk({t, ".a4"}, 32'(b4.cnt_a), cap(na, 15));
      chk({t, ".b4"}, 32'(b4.cnt_b), cap(nb, 15));
      chk({t, ".ab4"}, 32'(b4.cnt_ab), cap(nab, 15));
      chk({t, ".sat4"}, 32'(b4.sat), 32'(mx >= 15));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One acquisition: window w, pulses from va/vb per gated cycle.
   // abort_at: -1 none, -2 during ARM, else gated cycle index.
   task automatic acq(input int w, input int abort_at, input int start_at,
                      input int hold, input bit rnd);
      win = WIN_W'(w);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_ctl("arm", 1'b0, 1'b1, 1'b0);
      pa = 1'($urandom);
      pb = 1'($urandom);
      abort = (abort_at == -2);
      tick();
      pa = 1'b0; pb = 1'b0; abort = 1'b0;
      m_clear();
      if (abort_at == -2) begin
         chk_ctl("abort_arm", 1'b0, 1'b0, 1'b0);
         chk_out("abort_arm");
         return;
      end
      for (int k = 0; k < w; k++) begin
         chk_ctl("count", 1'b1, 1'b1, 1'b0);
         chk_out("count");
         pa = va[k];
         pb = vb[k];
         abort = (k == abort_at);
         start = (k == start_at) || (rnd && $urandom_range(0, 7) == 0);
         m_pulse(k, pa, pb);
         tick();
         pa = 1'b0; pb = 1'b0; abort = 1'b0; start = 1'b0;
         if (k == abort_at) begin
            chk_ctl("aborted", 1'b0, 1'b0, 1'b0);
            chk_out("aborted");
            return;
         end
      end
      for (int h = 0; h <= hold; h++) begin
         chk_ctl("hold", 1'b0, 1'b1, 1'b1);
         chk_out("hold");
         rdy = (h == hold);
         pa = 1'(h % 2);
         pb = 1'($urandom);
         if (rnd) begin
            start = 1'($urandom);
            abort = 1'($urandom);
         end
         tick();
         rdy = 1'b0; pa = 1'b0; pb = 1'b0; start = 1'b0; abort = 1'b0;
      end
      chk_ctl("done", 1'b0, 1'b0, 1'b0);
      chk_out("done");
   endtask

   initial begin
      int w, ab, pca, pcb;
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; pa = 1'b0; pb = 1'b0; rdy = 1'b0;
      win = '0;
      m_clear();
      repeat (3) tick();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk_out("reset");
      rst = 1'b0;
      tick();

      // 100-cycle window, 10 A pulses spaced 5 apart
      va = '0; vb = '0;
      for (int i = 0; i < 10; i++) va[i*5] = 1'b1;
      acq(100, -1, -1, 0, 1'b0);
      chk("tp1.a", 32'(b16.cnt_a), 32'd10);
      chk("tp1.b", 32'(b16.cnt_b), 32'd0);
      chk("tp1.ab", 32'(b16.cnt_ab), 32'd0);

      // pair at distance 3, non-pair at distance 4, simultaneous pair
      va = '0; vb = '0;
      va[0] = 1'b1; vb[3] = 1'b1;
      va[10] = 1'b1; vb[14] = 1'b1;
      va[20] = 1'b1; vb[20] = 1'b1;
      acq(30, -1, -1, 1, 1'b0);
      chk("tp2.ab", 32'(b16.cnt_ab), 32'd2);
      chk("tp2.a", 32'(b16.cnt_a), 32'd3);
      chk("tp2.b", 32'(b16.cnt_b), 32'd3);

      // consumed pulses do not re-pair
      va = '0; vb = '0;
      va[0] = 1'b1; vb[1] = 1'b1; va[2] = 1'b1;
      acq(10, -1, -1, 0, 1'b0);
      chk("tp3.ab", 32'(b16.cnt_ab), 32'd1);

      // 20 A pulses: 4-bit instance saturates
      va = '0; vb = '0;
      for (int i = 0; i < 20; i++) va[i*2] = 1'b1;
      acq(50, -1, -1, 0, 1'b0);
      chk("tp4.a4", 32'(b4.cnt_a), 32'd15);
      chk("tp4.sat4", 32'(b4.sat), 32'd1);
      chk("tp4.a16", 32'(b16.cnt_a), 32'd20);
      chk("tp4.sat16", 32'(b16.sat), 32'd0);

      // abort at gated cycle 10, extra start during COUNT is not queued
      for (int i = 0; i < 256; i++) begin
         va[i] = 1'($urandom);
         vb[i] = 1'($urandom);
      end
      acq(100, 10, 4, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_ctl("post_abort", 1'b0, 1'b0, 1'b0);
      end

      // long hold with ready low while pulse_a toggles
      acq(40, -1, -1, 50, 1'b0);

      // zero-length window and abort while arming
      acq(0, -1, -1, 2, 1'b0);
      acq(20, -2, -1, 0, 1'b0);

      // asynchronous reset in the middle of counting
      va = '1; vb = '0;
      win = WIN_W'(60);
      start = 1'b1;
      tick();
      start = 1'b0;
      pa = 1'b1;
      repeat (8) tick();
      #1 rst = 1'b1;
      #1;
      m_clear();
      chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0);
      chk_out("rst_mid");
      pa = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // randomized acquisitions
      for (int n = 0; n < 25; n++) begin
         w = $urandom_range(0, 120);
         pca = $urandom_range(0, 60);
         pcb = $urandom_range(0, 60);
         for (int i = 0; i < 256; i++) begin
            va[i] = ($urandom_range(0, 99) < pca);
            vb[i] = ($urandom_range(0, 99) < pcb);
         end
         ab = -1;
         if ($urandom_range(0, 4) == 0)
            ab = (w > 0) ? $urandom_range(0, w - 1) : -2;
         acq(w, ab, -1, $urandom_range(0, 5), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
